// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Machine-mode trap sequencer. When an instruction commits in IDLE, the block
// takes at most one event, in priority order timer interrupt, ecall, mret.
// Taking an event flushes the pipeline in that same cycle and latches the CSR
// update values and the redirect target. The following cycle (UPDATE) strobes
// csrUpdata. The block then sits in REDIRECT, presenting the target, until
// the fetch side accepts it.
//
// Configuration macro: TRAP_TIMER_IRQ_EN
//   defined   : timer_irq & gIntEn is taken as the highest-priority event
//   undefined : timer_irq is ignored (the port is kept); only ecall/mret taken
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   commit_valid/pc          committing instruction and its PC
//   commit_ecall/mret        instruction is an ecall / mret
//   timer_irq                level machine-timer interrupt request
//   csr_mtvec/mepc/mcause    current CSR values
//   gIntEn                   mstatus.MIE
//   mcause_n/mepc_n          new mcause/mepc values (held until next take)
//   mstatus_n                1 = trap entry (MIE cleared), 0 = mret
//   csrUpdata                one-cycle CSR write strobe
//   redirect_valid/pc        fetch redirect request and target
//   redirect_ready           fetch side accepts the redirect
//   flush                    one-cycle pipeline flush in the take cycle
//   commit_accept            high only in IDLE; commit stalls while low
// -----------------------------------------------------------------------------
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic        commit_ecall,
    input  logic        commit_mret,
    input  logic        timer_irq,
    input  logic [63:0] csr_mtvec,
    input  logic [63:0] csr_mepc,
    input  logic [63:0] csr_mcause,
    input  logic        gIntEn,
    output logic [63:0] mcause_n,
    output logic [63:0] mepc_n,
    output logic        mstatus_n,
    output logic        csrUpdata,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        commit_accept
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_UPDATE   = 2'b01,
        ST_REDIRECT = 2'b10
    } state_t;

    localparam logic [63:0] CAUSE_MTIMER = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL  = 64'd11;

    // Direct-mode trap vector: the low two mtvec bits are the MODE field.
    function automatic logic [63:0] vec_base(input logic [63:0] mtvec);
        return {mtvec[63:2], 2'b00};
    endfunction

    state_t      state_r;
    logic [63:0] mcause_r;
    logic [63:0] mepc_r;
    logic        mstatus_r;
    logic        csr_upd_r;
    logic        redirect_valid_r;
    logic [63:0] redirect_pc_r;
    logic        commit_accept_r;

    logic        irq_req_s;
    logic        take_s;
    logic [63:0] cause_nxt_s;
    logic [63:0] epc_nxt_s;
    logic        status_nxt_s;
    logic [63:0] target_nxt_s;

`ifdef TRAP_TIMER_IRQ_EN
    assign irq_req_s = timer_irq & gIntEn;
`else
    // The interrupt path is compiled out; the AND with zero keeps the
    // retained inputs referenced.
    assign irq_req_s = 1'b0 & timer_irq & gIntEn;
`endif

    // Event selection and the values latched when an event is taken.
    always_comb begin
        take_s       = 1'b0;
        cause_nxt_s  = 64'd0;
        epc_nxt_s    = 64'd0;
        status_nxt_s = 1'b0;
        target_nxt_s = 64'd0;
        if ((state_r == ST_IDLE) && commit_valid) begin
            if (irq_req_s) begin
                take_s       = 1'b1;
                cause_nxt_s  = CAUSE_MTIMER;
                epc_nxt_s    = commit_pc;
                status_nxt_s = 1'b1;
                target_nxt_s = vec_base(csr_mtvec);
            end else if (commit_ecall) begin
                take_s       = 1'b1;
                cause_nxt_s  = CAUSE_ECALL;
                epc_nxt_s    = commit_pc;
                status_nxt_s = 1'b1;
                target_nxt_s = vec_base(csr_mtvec);
            end else if (commit_mret) begin
                // mret rewrites mcause/mepc with their current values, so
                // the CSR strobe leaves them unchanged.
                take_s       = 1'b1;
                cause_nxt_s  = csr_mcause;
                epc_nxt_s    = csr_mepc;
                status_nxt_s = 1'b0;
                target_nxt_s = csr_mepc;
            end else begin
                take_s       = 1'b0;
            end
        end else begin
            take_s = 1'b0;
        end
    end

    // Trap sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            mcause_r         <= 64'd0;
            mepc_r           <= 64'd0;
            mstatus_r        <= 1'b0;
            csr_upd_r        <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 64'd0;
            commit_accept_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (take_s) begin
                        state_r         <= ST_UPDATE;
                        mcause_r        <= cause_nxt_s;
                        mepc_r          <= epc_nxt_s;
                        mstatus_r       <= status_nxt_s;
                        redirect_pc_r   <= target_nxt_s;
                        csr_upd_r       <= 1'b1;
                        commit_accept_r <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    state_r          <= ST_REDIRECT;
                    csr_upd_r        <= 1'b0;
                    redirect_valid_r <= 1'b1;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_r          <= ST_IDLE;
                        redirect_valid_r <= 1'b0;
                        commit_accept_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    csr_upd_r        <= 1'b0;
                    redirect_valid_r <= 1'b0;
                    commit_accept_r  <= 1'b1;
                end
            endcase
        end
    end

    // flush must be visible in the take cycle itself, so it is the only
    // output decoded from inputs; reset masks it immediately.
    assign flush          = take_s & ~rst;
    assign mcause_n       = mcause_r;
    assign mepc_n         = mepc_r;
    assign mstatus_n      = mstatus_r;
    assign csrUpdata      = csr_upd_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign commit_accept  = commit_accept_r;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//
// Randomised and directed bench for trap_ctrl. A transaction-level reference
// model decides from the architectural trap rules whether an event is taken
// and what mcause/mepc/mstatus/target result, and the bench checks the
// take / update / redirect sequence cycle by cycle. Inputs are driven 1 time
// unit after the rising edge and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

`ifdef TRAP_TIMER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, commit_ecall, commit_mret, timer_irq, gIntEn;
    logic [63:0] commit_pc, csr_mtvec, csr_mepc, csr_mcause;
    logic [63:0] mcause_n, mepc_n, redirect_pc;
    logic        mstatus_n, csrUpdata, redirect_valid, redirect_ready;
    logic        flush, commit_accept;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Architectural state the model expects the DUT to hold.
    logic [63:0] exp_cause = 64'd0;
    logic [63:0] exp_epc   = 64'd0;
    logic        exp_stat  = 1'b0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_ecall  (commit_ecall),
        .commit_mret   (commit_mret),
        .timer_irq     (timer_irq),
        .csr_mtvec     (csr_mtvec),
        .csr_mepc      (csr_mepc),
        .csr_mcause    (csr_mcause),
        .gIntEn        (gIntEn),
        .mcause_n      (mcause_n),
        .mepc_n        (mepc_n),
        .mstatus_n     (mstatus_n),
        .csrUpdata     (csrUpdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_ready(redirect_ready),
        .flush         (flush),
        .commit_accept (commit_accept)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_commit();
        commit_valid = 1'b0;
        commit_pc    = 64'd0;
        commit_ecall = 1'b0;
        commit_mret  = 1'b0;
        timer_irq    = 1'b0;
        gIntEn       = 1'b0;
    endtask

    // Random commit traffic that must be ignored while busy.
    task automatic scramble();
        commit_valid = 1'b1;
        commit_pc    = {$urandom, $urandom};
        commit_ecall = 1'($urandom_range(1));
        commit_mret  = 1'($urandom_range(1));
        timer_irq    = 1'($urandom_range(1));
        gIntEn       = 1'($urandom_range(1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_csrupd"}, 64'(csrUpdata), 64'd0);
        chk({tag, "_rvalid"}, 64'(redirect_valid), 64'd0);
        chk({tag, "_flush"},  64'(flush), 64'd0);
        chk({tag, "_mcause"}, mcause_n, 64'd0);
        chk({tag, "_mepc"},   mepc_n, 64'd0);
        chk({tag, "_mstat"},  64'(mstatus_n), 64'd0);
        chk({tag, "_rpc"},    redirect_pc, 64'd0);
        chk({tag, "_accept"}, 64'(commit_accept), 64'd1);
    endtask

    // One commit offered in IDLE, followed through the whole trap sequence
    // when the model says it is taken. rdly = cycles redirect_ready stays low.
    task automatic txn(input logic v, input logic [63:0] pc, input logic ec, input logic mr,
                       input logic ti, input logic ie, input logic [63:0] tv,
                       input logic [63:0] ep, input logic [63:0] mc, input int rdly);
        bit          is_irq, tk;
        logic [63:0] c, e, t;
        logic        s;
        is_irq = IRQ_EN && ti && ie;
        tk     = v && (is_irq || ec || mr);
        c = 64'd0; e = 64'd0; t = 64'd0; s = 1'b0;
        if (is_irq)  begin c = 64'h8000_0000_0000_0007; e = pc; s = 1'b1; t = tv & ~64'd3; end
        else if (ec) begin c = 64'd11; e = pc; s = 1'b1; t = tv & ~64'd3; end
        else if (mr) begin c = mc; e = ep; s = 1'b0; t = ep; end

        commit_valid = v; commit_pc = pc; commit_ecall = ec; commit_mret = mr;
        timer_irq = ti; gIntEn = ie; csr_mtvec = tv; csr_mepc = ep; csr_mcause = mc;
        redirect_ready = 1'($urandom_range(1));
        @(negedge clk);
        chk("accept_idle", 64'(commit_accept), 64'd1);
        chk("flush_take", 64'(flush), 64'(tk));
        if (!tk) begin
            @(posedge clk); #1;
            clear_commit();
            @(negedge clk);
            chk("accept_stay", 64'(commit_accept), 64'd1);
            chk("csrupd_none", 64'(csrUpdata), 64'd0);
            chk("mcause_hold", mcause_n, exp_cause);
        end else begin
            exp_cause = c; exp_epc = e; exp_stat = s;
            @(posedge clk); #1;
            scramble();
            redirect_ready = 1'($urandom_range(1));
            @(negedge clk);
            chk("upd_strobe", 64'(csrUpdata), 64'd1);
            chk("upd_mcause", mcause_n, exp_cause);
            chk("upd_mepc", mepc_n, exp_epc);
            chk("upd_mstat", 64'(mstatus_n), 64'(exp_stat));
            chk("upd_flush", 64'(flush), 64'd0);
            chk("upd_accept", 64'(commit_accept), 64'd0);
            chk("upd_rvalid", 64'(redirect_valid), 64'd0);
            for (int i = 0; i <= rdly; i++) begin
                @(posedge clk); #1;
                scramble();
                redirect_ready = (i == rdly);
                @(negedge clk);
                chk("rd_valid", 64'(redirect_valid), 64'd1);
                chk("rd_pc", redirect_pc, t);
                chk("rd_csrupd", 64'(csrUpdata), 64'd0);
                chk("rd_flush", 64'(flush), 64'd0);
                chk("rd_accept", 64'(commit_accept), 64'd0);
            end
            @(posedge clk); #1;
            clear_commit();
            redirect_ready = 1'b0;
            @(negedge clk);
            chk("back_accept", 64'(commit_accept), 64'd1);
            chk("back_rvalid", 64'(redirect_valid), 64'd0);
            chk("back_mcause", mcause_n, exp_cause);
            chk("back_mepc", mepc_n, exp_epc);
            chk("back_mstat", 64'(mstatus_n), 64'(exp_stat));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_commit();
        csr_mtvec = 64'd0; csr_mepc = 64'd0; csr_mcause = 64'd0;
        redirect_ready = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // ecall: target drops the mtvec mode bits.
        txn(1'b1, 64'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0101, 64'd0, 64'd0, 0);
        chk("ecall_rpc_hold", redirect_pc, 64'h8000_0100);
        // mret restores mepc as target and preserves mcause/mepc.
        txn(1'b1, 64'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0101, 64'h8000_0014, 64'd11, 1);
        chk("mret_rpc_hold", redirect_pc, 64'h8000_0014);
        // Interrupt + ecall together (interrupt wins only with the macro).
        txn(1'b1, 64'h8000_0020, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_0200, 64'd0, 64'd0, 0);
`ifdef TRAP_TIMER_IRQ_EN
        chk("irq_mcause", mcause_n, 64'h8000_0000_0000_0007);
`else
        chk("irq_off_mcause", mcause_n, 64'd11);
`endif
        chk("irq_mepc", mepc_n, 64'h8000_0020);
        // Masked interrupt on a plain commit, then unmasked plain commit.
        txn(1'b1, 64'h8000_0030, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0200, 64'd0, 64'd0, 0);
        txn(1'b1, 64'h8000_0034, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0300, 64'd0, 64'd0, 0);
        // ecall and mret together: ecall wins.
        txn(1'b1, 64'h8000_0040, 1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0400, 64'h55, 64'h66, 0);
        // Event without commit_valid is ignored.
        txn(1'b0, 64'h8000_0050, 1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0500, 64'h55, 64'h66, 0);
        // Backpressure: redirect_ready low for 5 cycles.
        txn(1'b1, 64'h8000_0060, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0600, 64'd0, 64'd0, 5);

        // Reset in UPDATE aborts without a CSR strobe.
        commit_valid = 1'b1; commit_ecall = 1'b1; commit_pc = 64'h8000_0070;
        csr_mtvec = 64'h8000_0700;
        @(negedge clk);
        chk("rst_pre_flush", 64'(flush), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_commit();
        #1;
        check_all_zero("rst_upd");
        @(negedge clk);
        chk("rst_no_strobe", 64'(csrUpdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cause = 64'd0; exp_epc = 64'd0; exp_stat = 1'b0;
        @(negedge clk);
        chk("rst_after_csrupd", 64'(csrUpdata), 64'd0);
        chk("rst_after_accept", 64'(commit_accept), 64'd1);
        @(posedge clk); #1;

        // Randomised traffic.
        for (int n = 0; n < 200; n++) begin
            txn(1'($urandom_range(3) != 0), {$urandom, $urandom},
                1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0),
                1'($urandom_range(3) == 0), 1'($urandom_range(1)),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
